mult_div_unit: RTL and testbench

- Iterative signed multiply/divide unit that feeds the HI/LO registers of the multicycle CPU datapath.
- Consumes the A/B register outputs on start pulses from the control FSM.
- Produces a 64-bit product or a quotient/remainder pair, plus done and div-by-zero flags.
- The control FSM waits on done, then loads HI/LO via the existing muxhigh/muxlow/highwrite/lowwrite path.

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/div_step.sv | 28 ++
 rtl/mult_div_unit.sv | 191 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package multdiv_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int MD_WIDTH = 32;

    // One Booth step or one restoring-division step per operand bit.
    localparam int MD_ITER = MD_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration on magnitudes
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic [W:0]   divisor,
    input  logic         dvd_bit,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W+1:0] diff;
    logic         unused_diff_bit;

    // Bring the next dividend bit into the partial remainder and trial-subtract.
    assign shifted = {rem_in, dvd_bit};
    assign diff    = {1'b0, shifted} - {1'b0, divisor};

    // No borrow means the divisor fits: keep the difference, quotient bit is 1.
    assign q_bit   = ~diff[W+1];
    assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

    // The kept remainder is always below the divisor (at most 2^(W-1)), so bit W
    // of the difference is zero whenever it is selected.
    assign unused_diff_bit = diff[W];

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed Booth multiply / restoring divide into HI/LO (optional MULTDIV_OVERFLOW_EN adds mult_overflow)
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
`ifdef MULTDIV_OVERFLOW_EN
    ,
    output logic             mult_overflow
`endif
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    md_state_t        state;
    md_state_t        state_next;
    logic [CW-1:0]    cnt;

    // acc: Booth upper accumulator, or partial remainder during division.
    // mq:  multiplier shifting out, or dividend shifting out / quotient shifting in.
    // mop: sign-extended multiplicand, or divisor magnitude.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic             qm1;
    logic [WIDTH:0]   mop;
    logic             sign_a;
    logic             sign_b;

    logic             b_zero;
    logic             accept_mult;
    logic             accept_div;
    logic             last_iter;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   a_mag;
    logic [WIDTH:0]   b_mag;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             unused_mag_msb;

    assign b_zero      = (b == '0);
    assign accept_mult = (state == IDLE) && start_mult;
    assign accept_div  = (state == IDLE) && !start_mult && start_div;
    assign last_iter   = (cnt == CNT_LAST);

    // Magnitudes are one bit wider so |-2^(WIDTH-1)| is representable.
    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = {b[WIDTH-1], b};
    assign a_mag = a[WIDTH-1] ? -a_ext : a_ext;
    assign b_mag = b[WIDTH-1] ? -b_ext : b_ext;

    // The dividend magnitude never exceeds 2^(WIDTH-1), so it fits the WIDTH-bit shifter.
    assign unused_mag_msb = a_mag[WIDTH];

    // Radix-2 Booth recoding of the current multiplier bit pair.
    always_comb begin
        booth_sum = acc;
        case ({mq[0], qm1})
            2'b01:   booth_sum = acc + mop;
            2'b10:   booth_sum = acc - mop;
            default: booth_sum = acc;
        endcase
    end

    div_step #(
        .W(WIDTH)
    ) u_div_step (
        .rem_in  (acc[WIDTH-1:0]),
        .divisor (mop),
        .dvd_bit (mq[WIDTH-1]),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the Moore busy/done outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_mult) begin
                    state_next = MULT;
                end else if (start_div) begin
                    state_next = b_zero ? DONE : DIV;
                end
            end
            MULT, DIV: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, one iteration per cycle, and the final HI/LO write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            qm1      <= 1'b0;
            mop      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
        end else if (accept_mult) begin
            mop      <= a_ext;
            mq       <= b;
            acc      <= '0;
            qm1      <= 1'b0;
            cnt      <= '0;
            div_zero <= 1'b0;
        end else if (accept_div) begin
            // A zero divisor only raises the flag; HI/LO keep their old contents.
            div_zero <= b_zero;
            if (!b_zero) begin
                acc    <= '0;
                mq     <= a_mag[WIDTH-1:0];
                mop    <= b_mag;
                sign_a <= a[WIDTH-1];
                sign_b <= b[WIDTH-1];
                cnt    <= '0;
            end
        end else if (state == MULT) begin
            if (!last_iter) begin
                acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                mq  <= {booth_sum[0], mq[WIDTH-1:1]};
                qm1 <= mq[0];
                cnt <= cnt + 1'b1;
            end else begin
                hi <= acc[WIDTH-1:0];
                lo <= mq;
            end
        end else if (state == DIV) begin
            if (!last_iter) begin
                acc <= {1'b0, rem_next};
                mq  <= {mq[WIDTH-2:0], q_bit};
                cnt <= cnt + 1'b1;
            end else begin
                // -2^(WIDTH-1) / -1 yields magnitude 2^(WIDTH-1), which wraps silently.
                lo <= (sign_a ^ sign_b) ? -mq : mq;
                hi <= sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

`ifdef MULTDIV_OVERFLOW_EN
    // Flag a product that does not fit in LO alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mult_overflow <= 1'b0;
        end else if (accept_mult || accept_div) begin
            mult_overflow <= 1'b0;
        end else if ((state == MULT) && last_iter) begin
            mult_overflow <= (acc[WIDTH-1:0] != {WIDTH{mq[WIDTH-1]}});
        end
    end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          start_mult = 1'b0;
    logic          start_div  = 1'b0;
    logic [W-1:0]  a          = '0;
    logic [W-1:0]  b          = '0;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic          div_zero;
`ifdef MULTDIV_OVERFLOW_EN
    logic          mult_overflow;
`endif

    int            checks = 0;
    int            fails  = 0;

    logic [W-1:0]  exp_hi  = '0;
    logic [W-1:0]  exp_lo  = '0;
    logic          exp_dz  = 1'b0;
    logic          exp_ovf = 1'b0;
    int            exp_lat = 0;

    mult_div_unit #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
`ifdef MULTDIV_OVERFLOW_EN
        ,
        .mult_overflow (mult_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic; SV / and % truncate toward zero.
    task automatic model(input logic m, input logic d, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint sa, sb, p, q, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (m) begin
            p       = sa * sb;
            exp_hi  = p[63:32];
            exp_lo  = p[31:0];
            exp_dz  = 1'b0;
            exp_ovf = (p != longint'($signed(p[31:0])));
            exp_lat = W + 1;
        end else if (d) begin
            exp_ovf = 1'b0;
            if (sb == 0) begin
                exp_dz  = 1'b1;
                exp_lat = 0;
            end else begin
                q       = sa / sb;
                r       = sa % sb;
                exp_hi  = r[31:0];
                exp_lo  = q[31:0];
                exp_dz  = 1'b0;
                exp_lat = W + 1;
            end
        end
    endtask

    // Issue one request, optionally pulse start_div (b=0) at cycle 'poke' while busy.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [W-1:0] av, input logic [W-1:0] bv, input int poke);
        int lat;
        model(m, d, av, bv);
        @(negedge clk);
        start_mult = m;
        start_div  = d;
        a          = av;
        b          = bv;
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        lat        = 0;
        chk({tag, " busy_after_accept"}, busy, (exp_lat > 0));
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == poke) begin
                start_div = 1'b1;
                b         = '0;
            end else begin
                start_div = 1'b0;
            end
        end
        start_div = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " div_zero"}, div_zero, exp_dz);
        chk({tag, " busy_at_done"}, busy, 1'b0);
`ifdef MULTDIV_OVERFLOW_EN
        chk({tag, " mult_overflow"}, mult_overflow, exp_ovf);
`endif
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int   done_cnt;
        logic m;
        logic [W-1:0] av, bv;
        int   sel;

        // Reset state.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset div_zero", div_zero, 1'b0);
`ifdef MULTDIV_OVERFLOW_EN
        chk("reset mult_overflow", mult_overflow, 1'b0);
`endif
        reset = 1'b1;

        // Directed cases.
        run_op("mult_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
        chk("mult_7_m3 const_hi", hi, 32'hFFFF_FFFF);
        chk("mult_7_m3 const_lo", lo, 32'hFFFF_FFEB);
        run_op("mult_large", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
        chk("mult_large const_hi", hi, 32'h3FFF_FFFF);
        chk("mult_large const_lo", lo, 32'h0000_0001);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        chk("div_m7_2 const_lo", lo, 32'hFFFF_FFFD);
        chk("div_m7_2 const_hi", hi, 32'hFFFF_FFFF);
        run_op("preload", 1'b1, 1'b0, 32'h0000_1234, 32'h0000_5678, -1);
        run_op("div_zero", 1'b0, 1'b1, 32'd5, 32'd0, -1);
        chk("div_zero const_hi", hi, 32'h0000_0000);
        chk("div_zero const_lo", lo, 32'h0626_0060);
        run_op("div_wrap", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("div_wrap const_lo", lo, 32'h8000_0000);
        chk("div_wrap const_hi", hi, 32'h0000_0000);
        run_op("both_starts", 1'b1, 1'b1, 32'd6, 32'd7, -1);
        run_op("div_while_busy", 1'b1, 1'b0, 32'hFFFF_0001, 32'h0001_0003, 5);

        // Reset during iteration 10 of a multiply.
        @(negedge clk);
        start_mult = 1'b1;
        a          = 32'h1357_9BDF;
        b          = 32'h2468_ACE0;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midreset busy", busy, 1'b0);
        chk("midreset hi", hi, 0);
        chk("midreset lo", lo, 0);
        chk("midreset done", done, 1'b0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("midreset no_done", done_cnt, 0);
        exp_hi  = '0;
        exp_lo  = '0;
        exp_dz  = 1'b0;
        exp_ovf = 1'b0;

        // Randomized operations against the model.
        for (int i = 0; i < 24; i++) begin
            m   = logic'($urandom_range(0, 1));
            av  = $urandom;
            sel = $urandom_range(0, 4);
            case (sel)
                0:       bv = $urandom_range(0, 3);
                1:       bv = 32'hFFFF_FFFF;
                2:       begin av = 32'h8000_0000; bv = $urandom; end
                default: bv = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), m, !m, av, bv, -1);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
